// File: rtl/left_rotate_register.sv
// left_rotate_register: DW-bit register with parallel load that rotates its
// contents left by one position on every enabled clock edge. The MSB wraps
// into bit 0, so a loaded word cycles through all bit positions. The output is
// driven straight from flops; there is no combinational path from inputs to q.
// Priority on each edge: reset, then load, then rotate, then hold.
module left_rotate_register #(
    parameter int DW = 4  // register width, must be >= 2
) (
    input  logic          clk,
    input  logic          async_rst,  // active-high, sampled on the clk edge
    input  logic          load,
    input  logic          en,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;

    // Next-state selection: load beats rotate, and hold is the default.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = data;
        end else if (en) begin
            q_d = {q_q[DW-2:0], q_q[DW-1]};
        end
    end

    // State register with synchronous reset to all zeros.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of q_q, whatever the block ordering.
        if (async_rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_left_rotate_register.sv
// Self-checking bench for left_rotate_register (DW=4). Inputs are driven on the
// falling edge and q is sampled 1 time unit after each rising edge.
module tb_left_rotate_register;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          async_rst = 1'b0;
    logic          load = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] data = '0;
    logic [DW-1:0] q;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference value of q, maintained from the operation rules.
    int model_q = 0;

    left_rotate_register #(.DW(DW)) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .load      (load),
        .en        (en),
        .data      (data),
        .q         (q)
    );

    always #5 clk = ~clk;

    // Left rotate expressed as arithmetic: doubling moves every bit up one
    // place modulo 2^DW, and the bit that falls off the top re-enters as 1.
    function automatic int rot_left(input int v);
        int m;
        m = 1 << DW;
        return ((v * 2) % m) + (v / (m / 2));
    endfunction

    // Apply one set of inputs across a single rising edge and update the model.
    task automatic cycle(input logic r, input logic l, input logic e, input logic [DW-1:0] d);
        @(negedge clk);
        async_rst = r;
        load      = l;
        en        = e;
        data      = d;
        @(posedge clk);
        if (r)      model_q = 0;
        else if (l) model_q = int'(d);
        else if (e) model_q = rot_left(model_q);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 4'b1010);
        total_cnt++;
        if (q !== 4'b0000) $display("FAIL reset: q=%b expected=%b", q, 4'b0000);
        else pass_cnt++;
        cycle(1'b0, 1'b0, 1'b1, 4'($urandom));
        total_cnt++;
        if (q !== 4'b0000) $display("FAIL rotate_zero_after_reset: q=%b expected=%b", q, 4'b0000);
        else pass_cnt++;
    endtask

    task automatic test_load_hold();
        cycle(1'b0, 1'b1, 1'b0, 4'b1011);
        total_cnt++;
        if (q !== 4'b1011) $display("FAIL load: q=%b expected=%b", q, 4'b1011);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 4'($urandom));
            total_cnt++;
            if (q !== 4'b1011) $display("FAIL hold[%0d]: q=%b expected=%b", i, q, 4'b1011);
            else pass_cnt++;
        end
    endtask

    task automatic test_rotate();
        logic [DW-1:0] exp_seq [5];
        exp_seq = '{4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        cycle(1'b0, 1'b1, 1'b0, 4'b1011);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 4'($urandom));
            total_cnt++;
            if (q !== exp_seq[i]) $display("FAIL rotate[%0d]: q=%b expected=%b", i, q, exp_seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_priority();
        logic [DW-1:0] exp_seq [4];
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        // q is 0111 here; one more rotate brings it to 1110.
        cycle(1'b0, 1'b0, 1'b1, 4'($urandom));
        total_cnt++;
        if (q !== 4'b1110) $display("FAIL prio_setup: q=%b expected=%b", q, 4'b1110);
        else pass_cnt++;
        cycle(1'b0, 1'b1, 1'b1, 4'b0001);
        total_cnt++;
        if (q !== 4'b0001) $display("FAIL load_over_rotate: q=%b expected=%b", q, 4'b0001);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 4'($urandom));
            total_cnt++;
            if (q !== exp_seq[i]) $display("FAIL prio_rotate[%0d]: q=%b expected=%b", i, q, exp_seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_rotation();
        logic [DW-1:0] exp_seq [3];
        exp_seq = '{4'b1100, 4'b1001, 4'b0011};
        cycle(1'b0, 1'b1, 1'b0, 4'b1110);
        cycle(1'b0, 1'b0, 1'b1, 4'($urandom));
        total_cnt++;
        if (q !== 4'b1101) $display("FAIL mid_setup: q=%b expected=%b", q, 4'b1101);
        else pass_cnt++;
        cycle(1'b1, 1'b0, 1'b1, 4'($urandom));
        total_cnt++;
        if (q !== 4'b0000) $display("FAIL reset_mid: q=%b expected=%b", q, 4'b0000);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 4'($urandom));
            total_cnt++;
            if (q !== 4'b0000) $display("FAIL zero_rotate[%0d]: q=%b expected=%b", i, q, 4'b0000);
            else pass_cnt++;
        end
        cycle(1'b0, 1'b1, 1'b0, 4'b0110);
        total_cnt++;
        if (q !== 4'b0110) $display("FAIL reload: q=%b expected=%b", q, 4'b0110);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 4'($urandom));
            total_cnt++;
            if (q !== exp_seq[i]) $display("FAIL reload_rotate[%0d]: q=%b expected=%b", i, q, exp_seq[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_all_ones();
        cycle(1'b0, 1'b1, 1'b0, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 4'($urandom));
            total_cnt++;
            if (q !== 4'b1111) $display("FAIL ones_rotate[%0d]: q=%b expected=%b", i, q, 4'b1111);
            else pass_cnt++;
        end
    endtask

    task automatic test_random_run();
        logic          r, l, e;
        logic [DW-1:0] d;
        for (int i = 0; i < 80; i++) begin
            r = (i % 29 == 13);
            l = (i % 7 == 0) || ($urandom_range(0, 5) == 0);
            e = 1'($urandom);
            d = 4'($urandom);
            cycle(r, l, e, d);
            total_cnt++;
            if (q !== 4'(model_q))
                $display("FAIL random[%0d]: q=%b expected=%b (rst=%b load=%b en=%b data=%b)",
                         i, q, 4'(model_q), r, l, e, d);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_rotate();
        test_load_priority();
        test_reset_mid_rotation();
        test_all_ones();
        test_random_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
